// File: rtl/if_id_ctrl_pkg.sv
// Shared constants, state encoding and source-register usage helpers for the IF/ID controller.
package if_id_ctrl_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_REDIRECT = 2'd1,
        CTRL_MEM_WAIT = 2'd2
    } ctrl_state_e;

    // rs1 is read by everything except the upper-immediate and JAL formats
    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
    endfunction

endpackage

// File: rtl/if_id_ctrl_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction held in IF/ID.
module hazard_detect
    import if_id_ctrl_pkg::*;
#(
    parameter int unsigned word_width = 32
) (
    input  logic [word_width-1:0] id_inst,
    input  logic                  id_valid,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rd,
    output logic                  lu_hazard
);

    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       unused_bits;

    assign opc         = id_inst[6:0];
    assign rs1         = id_inst[19:15];
    assign rs2         = id_inst[24:20];
    assign unused_bits = ^{id_inst[word_width-1:25], id_inst[14:7]};

    // x0 is never a real dependency
    assign lu_hazard = ex_mem_read && id_valid && (ex_rd != 5'd0) &&
                       ((uses_rs1(opc) && (rs1 == ex_rd)) ||
                        (uses_rs2(opc) && (rs2 == ex_rd)));

endmodule

// File: rtl/if_id_ctrl.sv
// Fetch-side pipeline controller: owns IF/ID, resolves redirects, load-use stalls and memory freezes.
module if_id_ctrl
    import if_id_ctrl_pkg::*;
#(
    parameter int unsigned addr_width = 32,
    parameter int unsigned word_width = 32,
    parameter int unsigned cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] if_inst,
    input  logic [addr_width-1:0] if_pc,
    input  logic                  ex_bch_taken,
    input  logic [addr_width-1:0] ex_bch_tgt,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rd,
    input  logic                  mem_busy,
    output logic                  pc_en,
    output logic                  stall_en,
    output logic                  jmp_bch_en,
    output logic [addr_width-1:0] jmp_bch_tgt,
    output logic [word_width-1:0] id_inst,
    output logic [addr_width-1:0] id_pc,
    output logic                  id_valid,
    output logic                  ex_bubble,
    output logic                  freeze,
    output logic [cnt_width-1:0]  stall_cnt,
    output logic [cnt_width-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ID_HOLD  = 2'd0,
        ID_LOAD  = 2'd1,
        ID_FLUSH = 2'd2
    } id_op_e;

    ctrl_state_e           state_q;
    ctrl_state_e           state_d;
    logic [addr_width-1:0] tgt_q;
    logic                  lu_hazard;
    id_op_e                id_op;
    logic                  tgt_load;
    logic                  flush_inc;

    hazard_detect #(
        .word_width (word_width)
    ) u_hazard_detect (
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .lu_hazard   (lu_hazard)
    );

    assign jmp_bch_tgt = tgt_q;

    // MEM_WAIT without mem_busy falls through to the RUN decision in the same cycle
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        stall_en   = 1'b0;
        jmp_bch_en = 1'b0;
        ex_bubble  = 1'b0;
        freeze     = 1'b0;
        id_op      = ID_HOLD;
        tgt_load   = 1'b0;
        flush_inc  = 1'b0;
        if (!rst) begin
            if (state_q == CTRL_REDIRECT) begin
                jmp_bch_en = 1'b1;
                stall_en   = 1'b1;
                ex_bubble  = 1'b1;
                if (mem_busy) begin
                    freeze = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    id_op   = ID_FLUSH;
                    state_d = CTRL_RUN;
                end
            end else if (mem_busy) begin
                freeze  = 1'b1;
                state_d = CTRL_MEM_WAIT;
            end else if (ex_bch_taken) begin
                pc_en     = 1'b1;
                stall_en  = 1'b1;
                ex_bubble = 1'b1;
                id_op     = ID_FLUSH;
                tgt_load  = 1'b1;
                flush_inc = 1'b1;
                state_d   = CTRL_REDIRECT;
            end else if (lu_hazard) begin
                ex_bubble = 1'b1;
                state_d   = CTRL_RUN;
            end else begin
                pc_en   = 1'b1;
                id_op   = ID_LOAD;
                state_d = CTRL_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CTRL_RUN;
            tgt_q     <= '0;
            id_inst   <= word_width'(NOP_INST);
            id_pc     <= '0;
            id_valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (tgt_load) begin
                tgt_q <= ex_bch_tgt;
            end
            case (id_op)
                ID_LOAD: begin
                    id_inst  <= if_inst;
                    id_pc    <= if_pc;
                    id_valid <= 1'b1;
                end
                ID_FLUSH: begin
                    id_inst  <= word_width'(NOP_INST);
                    id_pc    <= if_pc;
                    id_valid <= 1'b0;
                end
                default: ;
            endcase
            // both counters stick at all-ones
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + cnt_width'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + cnt_width'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_id_ctrl.sv
// Scoreboard bench for if_id_ctrl: driver pushes model predictions, monitor compares each cycle.
module tb_if_id_ctrl;
    import if_id_ctrl_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned WW = 32;
    localparam int unsigned CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WW-1:0] if_inst = '0;
    logic [AW-1:0] if_pc = '0;
    logic          ex_bch_taken = 1'b0;
    logic [AW-1:0] ex_bch_tgt = '0;
    logic          ex_mem_read = 1'b0;
    logic [4:0]    ex_rd = '0;
    logic          mem_busy = 1'b0;
    logic          pc_en, stall_en, jmp_bch_en, id_valid, ex_bubble, freeze;
    logic [AW-1:0] jmp_bch_tgt, id_pc;
    logic [WW-1:0] id_inst;
    logic [CW-1:0] stall_cnt, flush_cnt;

    if_id_ctrl #(.addr_width(AW), .word_width(WW), .cnt_width(CW)) dut (
        .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc(if_pc),
        .ex_bch_taken(ex_bch_taken), .ex_bch_tgt(ex_bch_tgt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_busy(mem_busy),
        .pc_en(pc_en), .stall_en(stall_en), .jmp_bch_en(jmp_bch_en),
        .jmp_bch_tgt(jmp_bch_tgt), .id_inst(id_inst), .id_pc(id_pc),
        .id_valid(id_valid), .ex_bubble(ex_bubble), .freeze(freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pc_en;
        logic          stall_en;
        logic          jmp_en;
        logic [AW-1:0] jmp_tgt;
        logic [WW-1:0] id_inst;
        logic [AW-1:0] id_pc;
        logic          id_valid;
        logic          ex_bubble;
        logic          freeze;
        logic [CW-1:0] stall_cnt;
        logic [CW-1:0] flush_cnt;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Abstract model: IF/ID contents, a pending-redirect flag and plain integer counters
    logic [WW-1:0] m_inst;
    logic [AW-1:0] m_pc;
    bit            m_valid;
    bit            m_pend;
    logic [AW-1:0] m_tgt;
    int            m_stall;
    int            m_flush;

    function automatic bit model_hazard(input logic [31:0] inst, input bit valid,
                                        input bit mr, input logic [4:0] rd);
        logic [6:0] op;
        bit r1, r2;
        op = inst[6:0];
        r1 = !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        r2 = op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
        if (!mr || !valid || rd == 5'd0) return 1'b0;
        return (r1 && inst[19:15] == rd) || (r2 && inst[24:20] == rd);
    endfunction

    task automatic step(input bit r, input logic [31:0] inst, input logic [31:0] pc,
                        input bit bch, input logic [31:0] tgt, input bit mr,
                        input logic [4:0] rd, input bit busy);
        obs_t e;
        bit load, flush;
        @(posedge clk);
        #1;
        rst = r; if_inst = inst; if_pc = pc; ex_bch_taken = bch; ex_bch_tgt = tgt;
        ex_mem_read = mr; ex_rd = rd; mem_busy = busy;
        e = '0;
        if (r) begin
            m_inst = NOP_INST; m_pc = '0; m_valid = 0; m_pend = 0; m_tgt = '0;
            m_stall = 0; m_flush = 0;
            e.id_inst = NOP_INST;
        end else begin
            e.jmp_tgt = m_tgt; e.id_inst = m_inst; e.id_pc = m_pc; e.id_valid = m_valid;
            e.stall_cnt = CW'(m_stall); e.flush_cnt = CW'(m_flush);
            load = 0; flush = 0;
            if (m_pend) begin
                e.jmp_en = 1; e.stall_en = 1; e.ex_bubble = 1;
                if (busy) e.freeze = 1;
                else begin e.pc_en = 1; flush = 1; m_pend = 0; end
            end else if (busy) begin
                e.freeze = 1;
            end else if (bch) begin
                e.pc_en = 1; e.stall_en = 1; e.ex_bubble = 1; flush = 1;
                m_pend = 1; m_tgt = tgt;
                m_flush = (m_flush + 1 > CNT_MAX) ? CNT_MAX : m_flush + 1;
            end else if (model_hazard(m_inst, m_valid, mr, rd)) begin
                e.ex_bubble = 1;
            end else begin
                e.pc_en = 1; load = 1;
            end
            if (!e.pc_en) m_stall = (m_stall + 1 > CNT_MAX) ? CNT_MAX : m_stall + 1;
            if (load) begin m_inst = inst; m_pc = pc; m_valid = 1; end
            if (flush) begin m_inst = NOP_INST; m_pc = pc; m_valid = 0; end
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [31:0] inst, input logic [31:0] pc);
        step(0, inst, pc, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented cycle against the oldest prediction
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{pc_en, stall_en, jmp_bch_en, jmp_bch_tgt, id_inst, id_pc, id_valid,
                      ex_bubble, freeze, stall_cnt, flush_cnt};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL cyc%0d act=%h req=%h", cyc, a, e);
                end
                cyc++;
            end
        end
    end

    localparam logic [31:0] ADD_3_1_2 = 32'h0020_81B3;
    localparam logic [31:0] LUI_RS1_2 = 32'h0001_00B7;
    localparam logic [31:0] ADDI_1    = 32'h0010_0093;

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10];
        ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                OPC_STORE, OPC_OP_IMM, OPC_OP, 7'($urandom)};
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom), ops[$urandom_range(0, 9)]};
    endfunction

    initial begin
        logic [31:0] pc;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // straight-line fetch
        for (int i = 0; i < 5; i++) run(ADDI_1 + 32'(i << 7), 32'(i * 4));
        // taken branch to 0x40 while id_pc=0x10
        step(0, ADDI_1, 32'h14, 1, 32'h40, 0, 0, 0);
        step(0, NOP_INST, 32'h18, 0, 0, 0, 0, 0);
        run(ADDI_1, 32'h40);
        // load-use: stall on rs2, no stall for x0 or LUI
        run(ADD_3_1_2, 32'h44);
        step(0, ADDI_1, 32'h48, 0, 0, 1, 5'd2, 0);
        step(0, ADDI_1, 32'h48, 0, 0, 0, 5'd0, 0);
        run(ADD_3_1_2, 32'h4C);
        step(0, ADDI_1, 32'h50, 0, 0, 1, 5'd0, 0);
        run(LUI_RS1_2, 32'h54);
        step(0, ADDI_1, 32'h58, 0, 0, 1, 5'd2, 0);
        // three-cycle memory freeze then resume
        for (int i = 0; i < 3; i++) step(0, ADDI_1, 32'h5C, 0, 0, 0, 0, 1);
        run(ADDI_1, 32'h5C);
        // redirect held by memory wait
        step(0, ADDI_1, 32'h60, 1, 32'h40, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, NOP_INST, 32'h64, 0, 0, 0, 0, 1);
        step(0, NOP_INST, 32'h64, 0, 0, 0, 0, 0);
        run(ADDI_1, 32'h40);
        // asynchronous reset in the middle of a redirect
        step(0, ADDI_1, 32'h44, 1, 32'h80, 0, 0, 0);
        step(1, NOP_INST, 32'h48, 0, 0, 0, 0, 0);
        run(ADDI_1, 32'h0);
        run(ADDI_1, 32'h4);
        // randomized traffic
        pc = 32'h100;
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), rand_inst(), pc,
                 ($urandom_range(0, 9) == 0), 32'($urandom) & 32'hFFFC,
                 ($urandom_range(0, 4) < 2), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 6) == 0));
            pc = pc + 32'd4;
        end
        // long freeze drives stall_cnt into saturation
        for (int i = 0; i < CNT_MAX + 40; i++) step(0, ADDI_1, pc, 0, 0, 0, 0, 1);
        run(ADDI_1, pc);
        run(ADDI_1, pc + 32'd4);
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain act=%0d req=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
